// File: rtl/data_io_upload.sv
// data_io_upload: SS2 SPI-slave upload path that reads core memory over an ioctl read port and shifts it out on SPI_DO (optional CRC readback: UPLOAD_CRC_EN)
module data_io_upload #(
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              SPI_SCK,
  input  logic              SPI_SS2,
  input  logic              SPI_DI,
  output logic              SPI_DO,
  output logic              SPI_DO_OE,
  output logic              ioctl_upload,
  output logic [7:0]        ioctl_index,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic              ioctl_rd,
  input  logic [7:0]        ioctl_din
);
  typedef enum logic [2:0] {CMD, PARAM, STREAM, IGNORE, CRC} state_t;
  state_t      state;
  logic [2:0]  sck_q;
  logic [1:0]  ss_q, di_q;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [7:0]  tx_sr, buf_data, rx_byte;
  logic        buf_valid, load, param_ctrl, ss, sck_rise, sck_fall, byte_done;
  logic [3:0]  rd_cnt;
`ifdef UPLOAD_CRC_EN
  logic [15:0] crc;
  logic        crc_lo;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? {r[14:0], 1'b0} ^ 16'h1021 : {r[14:0], 1'b0};
    return r;
  endfunction
`endif
  assign ss        = ss_q[1];
  assign sck_rise  = ~ss & sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~ss & ~sck_q[1] & sck_q[2];
  assign byte_done = sck_rise & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr, di_q[1]};
  assign SPI_DO    = tx_sr[7];
  // two-flop synchronizers; SCK keeps a third stage for edge detection so SS2 and SCK edges line up
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sck_q <= 3'b000;
      ss_q  <= 2'b11;
      di_q  <= 2'b00;
    end else begin
      sck_q <= {sck_q[1:0], SPI_SCK};
      ss_q  <= {ss_q[0], SPI_SS2};
      di_q  <= {di_q[0], SPI_DI};
    end
  end
  // command FSM, bit receive/transmit, prefetch buffer and read strobe
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= CMD;
      bit_cnt      <= 3'd0;
      rx_sr        <= 7'd0;
      param_ctrl   <= 1'b0;
      load         <= 1'b0;
      tx_sr        <= 8'h00;
      SPI_DO_OE    <= 1'b0;
      ioctl_upload <= 1'b0;
      ioctl_index  <= 8'h00;
      ioctl_addr   <= '0;
      ioctl_rd     <= 1'b0;
      buf_data     <= 8'h00;
      buf_valid    <= 1'b0;
      rd_cnt       <= 4'd0;
`ifdef UPLOAD_CRC_EN
      crc          <= 16'hFFFF;
      crc_lo       <= 1'b0;
`endif
    end else begin
      ioctl_rd <= 1'b0;
      load     <= 1'b0;
      if (rd_cnt != 4'd0) rd_cnt <= rd_cnt - 4'd1;
      if (ioctl_rd) rd_cnt <= 4'(RD_LATENCY);
      if (rd_cnt == 4'd1) begin
        buf_data  <= ioctl_din;
        buf_valid <= 1'b1;
      end
      if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sr   <= rx_byte[6:0];
      end
      if (sck_fall && bit_cnt != 3'd0) tx_sr <= {tx_sr[6:0], 1'b0};
      if (load && state == STREAM) begin
        tx_sr     <= buf_valid ? buf_data : 8'h00;
        buf_valid <= 1'b0;
        ioctl_rd  <= 1'b1;
        if (buf_valid) ioctl_addr <= ioctl_addr + 1'b1;
`ifdef UPLOAD_CRC_EN
        crc <= crc_step(crc, buf_valid ? buf_data : 8'h00);
`endif
      end
`ifdef UPLOAD_CRC_EN
      if (load && state == CRC) tx_sr <= crc_lo ? crc[7:0] : crc[15:8];
`endif
      if (ss) begin
        state     <= CMD;
        bit_cnt   <= 3'd0;
        SPI_DO_OE <= 1'b0;
        load      <= 1'b0;
      end else if (byte_done) begin
        case (state)
          CMD: begin
            if (rx_byte == 8'h55 || rx_byte == 8'h56) begin
              state      <= PARAM;
              param_ctrl <= ~rx_byte[0];
            end else if (rx_byte == 8'h57 && ioctl_upload) begin
              state     <= STREAM;
              SPI_DO_OE <= 1'b1;
              load      <= 1'b1;
`ifdef UPLOAD_CRC_EN
            end else if (rx_byte == 8'h5A) begin
              state     <= CRC;
              SPI_DO_OE <= 1'b1;
              load      <= 1'b1;
              crc_lo    <= 1'b0;
`endif
            end else state <= IGNORE;
          end
          PARAM: begin
            state <= IGNORE;
            if (!param_ctrl) ioctl_index <= rx_byte;
            else if (rx_byte != 8'h00) begin
              ioctl_upload <= 1'b1;
              ioctl_addr   <= '0;
              buf_valid    <= 1'b0;
              rd_cnt       <= 4'd0;
              ioctl_rd     <= 1'b1;
`ifdef UPLOAD_CRC_EN
              crc          <= 16'hFFFF;
`endif
            end else begin
              ioctl_upload <= 1'b0;
              buf_valid    <= 1'b0;
              rd_cnt       <= 4'd0;
            end
          end
          STREAM: load <= 1'b1;
`ifdef UPLOAD_CRC_EN
          CRC: begin
            if (crc_lo) state <= IGNORE;
            else begin
              load   <= 1'b1;
              crc_lo <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_data_io_upload.sv
// tb_data_io_upload: directed SPI sessions against data_io_upload with a latency-2 memory model (CRC checks when UPLOAD_CRC_EN)
module tb_data_io_upload;
  logic       clk_sys = 1'b0, reset_n = 1'b0;
  logic       SPI_SCK = 1'b0, SPI_SS2 = 1'b1, SPI_DI = 1'b0;
  logic       SPI_DO, SPI_DO_OE, ioctl_upload, ioctl_rd;
  logic [7:0] ioctl_index, ioctl_din, rx;
  logic [3:0] ioctl_addr, a1, a2;
  logic       r1 = 1'b0, r2 = 1'b0;
  logic       mem_mode = 1'b0;
  int         checks = 0, errors = 0, rd_count = 0, oe_count = 0, snap;

  data_io_upload #(.RD_LATENCY(2), .ADDR_W(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2),
    .SPI_DI(SPI_DI), .SPI_DO(SPI_DO), .SPI_DO_OE(SPI_DO_OE), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din)
  );

  always #5 clk_sys = ~clk_sys;

  // memory answers two cycles after the read strobe, garbage otherwise
  always @(posedge clk_sys) begin
    r1 <= ioctl_rd;
    a1 <= ioctl_addr;
    r2 <= r1;
    a2 <= a1;
    if (ioctl_rd) rd_count <= rd_count + 1;
    if (SPI_DO_OE) oe_count <= oe_count + 1;
  end
  assign ioctl_din = !r2 ? 8'hEE : mem_mode ? 8'h31 + {4'h0, a2} : {4'h0, a2} ^ 8'hA5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] got, input bit last);
    for (int i = 7; i >= 0; i--) begin
      SPI_DI = tx[i];
      #80;
      got[i] = SPI_DO;
      SPI_SCK = 1'b1;
      if (last && i == 0) SPI_SS2 = 1'b1;
      #80;
      SPI_SCK = 1'b0;
    end
    if (last) #160;
  endtask

  task automatic ss_low;
    SPI_SS2 = 1'b0;
    #80;
  endtask

  task automatic ss_high;
    #80;
    SPI_SS2 = 1'b1;
    #160;
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    ss_low;
    spi_byte(a, d, 1'b0);
    spi_byte(b, d, 1'b0);
    ss_high;
  endtask

  initial begin
    #50;
    check("rst_do", SPI_DO, 0);
    check("rst_oe", SPI_DO_OE, 0);
    check("rst_upload", ioctl_upload, 0);
    check("rst_index", ioctl_index, 0);
    check("rst_addr", ioctl_addr, 0);
    check("rst_rd", ioctl_rd, 0);
    #50;
    reset_n = 1'b1;
    #100;
    send2(8'h55, 8'h03);
    check("index", ioctl_index, 8'h03);
    snap = rd_count;
    send2(8'h56, 8'h01);
    check("start_upload", ioctl_upload, 1);
    check("start_addr", ioctl_addr, 0);
    check("start_rd", rd_count - snap, 1);
    ss_low;
    spi_byte(8'h57, rx, 1'b0);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx, i == 3);
      check($sformatf("strA%0d", i), rx, 8'hA5 ^ 8'(i));
    end
    check("strA_addr", ioctl_addr, 4);
    send2(8'h56, 8'h01);
    check("restart_addr", ioctl_addr, 0);
    ss_low;
    spi_byte(8'h57, rx, 1'b0);
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'h00, rx, i == 1);
      check($sformatf("strB%0d", i), rx, 8'hA5 ^ 8'(i));
    end
    ss_low;
    spi_byte(8'h57, rx, 1'b0);
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'h00, rx, i == 1);
      check($sformatf("strC%0d", i), rx, 8'hA7 ^ 8'(i));
    end
    check("strC_addr", ioctl_addr, 4);
    send2(8'h56, 8'h00);
    check("stop_upload", ioctl_upload, 0);
    snap = oe_count;
    send2(8'h57, 8'h00);
    check("data_idle_oe", oe_count - snap, 0);
`ifdef UPLOAD_CRC_EN
    mem_mode = 1'b1;
    send2(8'h56, 8'h01);
    ss_low;
    spi_byte(8'h57, rx, 1'b0);
    for (int i = 0; i < 9; i++) begin
      spi_byte(8'h00, rx, i == 8);
      check($sformatf("crc_data%0d", i), rx, 8'h31 + 8'(i));
    end
    ss_low;
    spi_byte(8'h5A, rx, 1'b0);
    spi_byte(8'h00, rx, 1'b0);
    check("crc_msb", rx, 8'h29);
    spi_byte(8'h00, rx, 1'b1);
    check("crc_lsb", rx, 8'hB1);
    mem_mode = 1'b0;
`else
    snap = oe_count;
    send2(8'h5A, 8'h00);
    check("crc_cmd_oe", oe_count - snap, 0);
`endif
    send2(8'h56, 8'h01);
    ss_low;
    spi_byte(8'h57, rx, 1'b0);
    for (int i = 0; i < 17; i++) begin
      spi_byte(8'h00, rx, i == 16);
      check($sformatf("wrap%0d", i), rx, 8'hA5 ^ 8'(i & 15));
    end
    check("wrap_addr", ioctl_addr, 1);
    ss_low;
    spi_byte(8'h57, rx, 1'b0);
    spi_byte(8'h00, rx, 1'b0);
    SPI_DI = 1'b1;
    #80;
    SPI_SCK = 1'b1;
    #40;
    check("mid_oe", SPI_DO_OE, 1);
    reset_n = 1'b0;
    #1;
    check("mid_do", SPI_DO, 0);
    check("mid_oe_rst", SPI_DO_OE, 0);
    check("mid_upload", ioctl_upload, 0);
    check("mid_index", ioctl_index, 0);
    check("mid_addr", ioctl_addr, 0);
    check("mid_rd", ioctl_rd, 0);
    #39;
    SPI_SCK = 1'b0;
    SPI_SS2 = 1'b1;
    #40;
    reset_n = 1'b1;
    #100;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
